// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - RV32I opcodes, immediate types and decode helpers
package rv32i_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_JAL      = 7'h6F;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM   = 7'h73;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic logic opc_legal(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM:
                opc_legal = 1'b1;
            default:
                opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_imm_gen.sv
// rtl/rv32i_imm_gen.sv - combinational RV32I immediate generator
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] imm,
    output imm_type_e       imm_type
);

    always_comb begin
        imm_type = IMM_NONE;
        imm      = '0;
        case (instr[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm_type = IMM_I;
                imm      = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                imm_type = IMM_S;
                imm      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                imm_type = IMM_B;
                imm      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type = IMM_U;
                imm      = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                imm_type = IMM_J;
                imm      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            default: begin
                imm_type = IMM_NONE;
                imm      = '0;
            end
        endcase
    end

endmodule

// File: rtl/id_operand_stage.sv
// rtl/id_operand_stage.sv - RV32I decode/operand fetch with forwarding and load-use stall
module id_operand_stage
    import rv32i_pkg::*;
#(
    parameter int ENABLE_FWD = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [XLEN-1:0]   if_pc,
    input  logic [XLEN-1:0]   if_instr,
    output logic [REG_AW-1:0] rf_rs1_addr,
    input  logic [XLEN-1:0]   rf_rs1_data,
    output logic [REG_AW-1:0] rf_rs2_addr,
    input  logic [XLEN-1:0]   rf_rs2_data,
    input  logic              ex_fwd_we,
    input  logic [REG_AW-1:0] ex_fwd_rd,
    input  logic [XLEN-1:0]   ex_fwd_data,
    input  logic              ex_is_load,
    input  logic              mem_fwd_we,
    input  logic [REG_AW-1:0] mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [XLEN-1:0]   id_pc,
    output logic [XLEN-1:0]   id_rs1_val,
    output logic [XLEN-1:0]   id_rs2_val,
    output logic [XLEN-1:0]   id_imm,
    output logic [REG_AW-1:0] id_rd,
    output logic [6:0]        id_opcode,
    output logic [2:0]        id_funct3,
    output logic              id_funct7b5,
    output logic              id_illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic FWD_ON = (ENABLE_FWD != 0);

    logic [6:0]      opcode;
    logic            legal;
    logic            use_rs1;
    logic            use_rs2;
    logic            writes_rd;
    logic [XLEN-1:0] imm;
    imm_type_e       imm_type;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hz;
    logic            adv;

    assign opcode      = if_instr[6:0];
    assign rf_rs1_addr = if_instr[19:15];
    assign rf_rs2_addr = if_instr[24:20];

    rv32i_imm_gen u_imm_gen (
        .instr    (if_instr),
        .imm      (imm),
        .imm_type (imm_type)
    );

    // Illegal opcodes claim no sources so they never stall.
    assign legal     = opc_legal(opcode);
    assign use_rs1   = legal && (imm_type != IMM_U) && (imm_type != IMM_J);
    assign use_rs2   = legal && ((imm_type == IMM_S) || (imm_type == IMM_B) || (opcode == OPC_OP));
    assign writes_rd = legal && (opcode != OPC_STORE) && (opcode != OPC_BRANCH) && (opcode != OPC_SYSTEM);

    // WB bypass stays on even without forwarding: the regfile write lands after this read.
    function automatic logic [XLEN-1:0] resolve(input logic [REG_AW-1:0] a, input logic [XLEN-1:0] rf);
        if (a == '0)
            resolve = '0;
        else if (FWD_ON && ex_fwd_we && !ex_is_load && (ex_fwd_rd == a))
            resolve = ex_fwd_data;
        else if (FWD_ON && mem_fwd_we && (mem_fwd_rd == a))
            resolve = mem_fwd_data;
        else if (wb_we && (wb_rd == a))
            resolve = wb_data;
        else
            resolve = rf;
    endfunction

    function automatic logic src_hz(input logic [REG_AW-1:0] a, input logic used);
        logic ex_match;
        logic mem_match;
        ex_match  = ex_fwd_we && (ex_fwd_rd != '0) && (ex_fwd_rd == a);
        mem_match = mem_fwd_we && (mem_fwd_rd != '0) && (mem_fwd_rd == a);
        src_hz    = used && ((ex_match && ex_is_load) || (!FWD_ON && (ex_match || mem_match)));
    endfunction

    always_comb begin
        rs1_val = resolve(rf_rs1_addr, rf_rs1_data);
        rs2_val = resolve(rf_rs2_addr, rf_rs2_data);
    end

    assign hz       = if_valid && (src_hz(rf_rs1_addr, use_rs1) || src_hz(rf_rs2_addr, use_rs2));
    assign adv      = !id_valid || id_ready;
    assign if_ready = adv && !hz && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_rs1_val  <= '0;
            id_rs2_val  <= '0;
            id_imm      <= '0;
            id_rd       <= '0;
            id_opcode   <= '0;
            id_funct3   <= '0;
            id_funct7b5 <= 1'b0;
            id_illegal  <= 1'b0;
            stall_cnt   <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (adv) begin
            if (hz) begin
                id_valid  <= 1'b0;
                stall_cnt <= stall_cnt + CNT_W'(1);
            end else if (if_valid) begin
                id_valid    <= 1'b1;
                id_pc       <= if_pc;
                id_rs1_val  <= rs1_val;
                id_rs2_val  <= rs2_val;
                id_imm      <= imm;
                id_rd       <= writes_rd ? if_instr[11:7] : '0;
                id_opcode   <= opcode;
                id_funct3   <= if_instr[14:12];
                id_funct7b5 <= if_instr[30];
                id_illegal  <= !legal;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- RV32I decode/operand-fetch stage; the read-side client of the 32x32 register file.
- Accepts fetched instructions over a valid/ready handshake and drives rs1/rs2 read addresses to the register file (combinational read).
- Resolves operands with EX/MEM/WB forwarding, generates immediates, and detects load-use hazards.
- Presents one registered decoded packet per instruction to EX.

Parameters:
- ENABLE_FWD, 1, 1 = EX/MEM/WB bypass active; 0 = regfile value plus WB bypass only; EX/MEM RAW then stalls until the producer has left MEM.
- CNT_W, 32, width of stall performance counter.

Ports:
- clk in 1 clock.
- rst in 1 synchronous, active-high reset.
- if_valid in 1 fetch packet valid.
- if_ready out 1 stage can accept.
- if_pc in 32 instruction PC.
- if_instr in 32 instruction word.
- rf_rs1_addr out 5 regfile read address 1 (= if_instr[19:15]).
- rf_rs1_data in 32 regfile read data 1.
- rf_rs2_addr out 5 regfile read address 2 (= if_instr[24:20]).
- rf_rs2_data in 32 regfile read data 2.
- ex_fwd_we in 1 EX will write rd.
- ex_fwd_rd in 5 EX destination.
- ex_fwd_data in 32 EX result.
- ex_is_load in 1 EX instruction is a load (data not yet available).
- mem_fwd_we in 1 MEM will write rd.
- mem_fwd_rd in 5 MEM destination.
- mem_fwd_data in 32 MEM result, loads included.
- wb_we in 1 regfile write enable this cycle.
- wb_rd in 5 regfile write address.
- wb_data in 32 regfile write data.
- flush in 1 kill in-flight decode (branch/jump redirect).
- id_valid out 1 decoded packet valid.
- id_ready in 1 EX accepts.
- id_pc out 32 PC.
- id_rs1_val out 32 resolved operand 1.
- id_rs2_val out 32 resolved operand 2.
- id_imm out 32 sign-extended immediate.
- id_rd out 5 destination (0 if no write).
- id_opcode out 7 opcode.
- id_funct3 out 3 funct3.
- id_funct7b5 out 1 instr[30].
- id_illegal out 1 opcode not RV32I.
- stall_cnt out CNT_W count of load-use stall cycles.

Behaviour:
- Reset: id_valid=0, all id_* data outputs=0, stall_cnt=0. Precedence: rst > flush > normal operation.
- Output register advance: adv = !id_valid || id_ready.
- Load-use hazard (hz) when all of the following hold:
  - if_valid=1 and ex_is_load=1 and ex_fwd_we=1 and ex_fwd_rd!=0;
  - ex_fwd_rd matches a used source.
- Source usage:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used by OP, STORE and BRANCH.
- With ENABLE_FWD=0, hz additionally covers any EX or MEM rd match on a used source.
- Handshake:
  - if_ready = adv && !hz && !flush.
  - A transfer occurs when if_valid && if_ready; the packet is registered at that edge. Latency is one cycle.
- Stall insertion: if adv && hz, the next edge sets id_valid=0 (bubble) and stall_cnt increments, wrapping at 2^CNT_W.
- Hold: if !adv, all id_* outputs hold stable and nothing is accepted. The hz count is not incremented in this case.
- Flush: the next edge sets id_valid=0. The incoming packet is not accepted. stall_cnt is unchanged.
- Operand resolution, per source with address a:
  - a==0 gives 0.
  - Otherwise, first match wins: EX (we, rd==a, not load) > MEM (we, rd==a) > WB (wb_we, wb_rd==a) > rf data.
  - The WB bypass is always active, because the regfile write is not visible in the same cycle.
- Immediates, sign bit instr[31]:
  - I-type: OP-IMM, LOAD, JALR.
  - S-type: STORE.
  - B-type: BRANCH, with bit0=0.
  - U-type: LUI, AUIPC, giving instr[31:12]<<12.
  - J-type: JAL.
  - All other opcodes give imm=0.
- id_rd = instr[11:7] for opcodes that write rd. For STORE, BRANCH, SYSTEM and illegal opcodes, id_rd=0.
- Legal opcodes: 0x37, 0x17, 0x6F, 0x67, 0x63, 0x03, 0x23, 0x13, 0x33, 0x0F, 0x73.
- Illegal opcodes pass through with id_illegal=1, no stall, and no rd write.
- rf_rs*_addr are driven combinationally from if_instr regardless of if_valid.

Decomposition:
- Shared package rv32i_pkg holds:
  - opcode localparams (OPC_LUI ... OPC_SYSTEM);
  - immediate-type enum (IMM_I/S/B/U/J/NONE);
  - XLEN=32 and REG_AW=5.
- One natural sub-module, rv32i_imm_gen: combinational instr -> imm plus type.
- Forwarding muxes and hazard logic stay inline.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with rf returning 0 → one cycle later id_valid=1, id_imm=5, id_rd=1, id_rs1_val=0.
- ADD x3,x1,x2 (0x002081B3), ex_fwd_we=1, ex_fwd_rd=1, ex_fwd_data=0xAA, mem_fwd_rd=1, mem_fwd_data=0xBB, rf2=7 → id_rs1_val=0xAA (EX priority), id_rs2_val=7.
- EX holds LW x5,0(x1), i.e. ex_is_load=1, ex_fwd_rd=5; present ADD x6,x5,x2 (0x00228333):
  - stall cycle: if_ready=0, one bubble with id_valid=0, stall_cnt=1;
  - next cycle, with MEM data 0x1234 on rd=5: accepted and id_rs1_val=0x1234.
- wb_we=1, wb_rd=2, wb_data=0x55, rf2 stale 0; SW x2,-4(x1) (0xFE20AE23) → id_rs2_val=0x55, id_imm=0xFFFFFFFC, id_rd=0.
- id_ready=0 with a valid packet held for 3 cycles → outputs stable, if_ready=0, stall_cnt unchanged. Then flush=1 → id_valid=0 next edge, no packet accepted that cycle.
- Opcode 0x7F → id_illegal=1, id_rd=0, id_imm=0. Also, rs1 address 0 with ex_fwd_rd=0 and ex_fwd_we=1 → operand reads 0.
